// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: collects SIZE bits (MSB first) from a valid/ready
// stream, pulses a load strobe for the downstream register, then waits for done/ack.
module serial_word_assembler #(
   parameter int SIZE  = 3,
   parameter int CNT_W = $clog2(SIZE + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            serIn,
   input  logic            serValid,
   output logic            serReady,
   output logic [SIZE-1:0] wordOut,
   output logic            ldOut,
   output logic            busy,
   output logic            done,
   input  logic            ack
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD,
      DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [SIZE-1:0]   shift_reg, shift_next;
   logic [CNT_W-1:0]  cnt_reg,   cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
      end
   end

   // The shift register only changes on start (clear) or an accepted bit, so wordOut
   // stays stable through LOAD and DONE until the next word begins.
   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
               shift_next = '0;
               cnt_next   = '0;
            end
         end
         SHIFT: begin
            if (serValid) begin
               shift_next = {shift_reg[SIZE-2:0], serIn};
               cnt_next   = cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(SIZE - 1)) begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            state_next = DONE;
         end
         DONE: begin
            if (ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign serReady = (state_reg == SHIFT);
   assign ldOut    = (state_reg == LOAD);
   assign done     = (state_reg == DONE);
   assign busy     = (state_reg != IDLE);
   assign wordOut  = shift_reg;

endmodule
